// File: rtl/password_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : password_store_ctrl
// Purpose  : Supervisor between the keypad front-end and the serial password
//            validator. Owns the 4-digit password store, forwards keypad
//            digits to the validator as one-cycle strobes, handles entry
//            timeout, lockdown and relock, and runs an atomic change-password
//            transaction after a successful unlock.
// Ports    : CLK, RST (async, active-low)
//            digitValid/digitIn       keypad digit strobe and BCD value
//            setReq/relockReq         requests honoured only while OPEN
//            addrRd -> dataRd         validator read port on committed store
//            unlockIn/lockDownIn      validator status
//            enableOut/digitOut       digit strobe towards the validator
//            restartOut               validator restart pulse
//            timeoutErr/setDone       event pulses
//            isOpen/dbgState          status
// Revision : 1.0 - initial release
// ============================================================================
module password_store_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES   = 1000,
  parameter logic [15:0] DEFAULT_PASSWORD = 16'h9210
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       digitValid,
  input  logic [3:0] digitIn,
  input  logic       setReq,
  input  logic       relockReq,
  input  logic [1:0] addrRd,
  output logic [3:0] dataRd,
  input  logic       unlockIn,
  input  logic       lockDownIn,
  output logic       enableOut,
  output logic [3:0] digitOut,
  output logic       restartOut,
  output logic       timeoutErr,
  output logic       setDone,
  output logic       isOpen,
  output logic [2:0] dbgState
);

  // Counter only ever holds 0..TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ENTER  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_OPEN   = 3'd3,
    ST_SET    = 3'd4,
    ST_COMMIT = 3'd5,
    ST_LOCK   = 3'd6
  } state_t;

  state_t        state_q,   state_d;
  logic [2:0]    dcnt_q,    dcnt_d;
  logic [1:0]    slot_q,    slot_d;
  logic [TW-1:0] tcnt_q,    tcnt_d;
  logic [15:0]   store_q,   store_d;
  logic [15:0]   shadow_q,  shadow_d;
  logic          en_q,      en_d;
  logic [3:0]    dig_q,     dig_d;
  logic          restart_q, restart_d;
  logic          tout_q,    tout_d;
  logic          done_q,    done_d;

  logic digit_ok;
  logic tmo_last;

  assign digit_ok = digitValid && (digitIn <= 4'd9);
  assign tmo_last = (tcnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    slot_d    = slot_q;
    tcnt_d    = tcnt_q;
    store_d   = store_q;
    shadow_d  = shadow_q;
    en_d      = 1'b0;
    dig_d     = dig_q;
    restart_d = 1'b0;
    tout_d    = 1'b0;
    done_d    = 1'b0;

    if (lockDownIn) begin
      // Lockdown overrides everything, including a commit in flight.
      state_d = ST_LOCK;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (digit_ok) begin
            en_d    = 1'b1;
            dig_d   = digitIn;
            dcnt_d  = 3'd1;
            state_d = ST_ENTER;
          end
        end

        ST_ENTER: begin
          if (dcnt_q == 3'd4) begin
            // The 4th strobe is on the wire this cycle; give the validator
            // one cycle to settle before CHECK looks at unlockIn.
            state_d = ST_CHECK;
          end else if (digit_ok) begin
            en_d   = 1'b1;
            dig_d  = digitIn;
            dcnt_d = dcnt_q + 3'd1;
            tcnt_d = '0;
          end else if (tmo_last) begin
            tout_d    = 1'b1;
            restart_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          if (unlockIn) begin
            state_d = ST_OPEN;
          end else begin
            restart_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end

        ST_OPEN: begin
          if (relockReq) begin
            restart_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (setReq) begin
            slot_d   = 2'd0;
            shadow_d = '0;
            state_d  = ST_SET;
          end
        end

        ST_SET: begin
          if (digit_ok) begin
            unique case (slot_q)
              2'd0:    shadow_d[3:0]   = digitIn;
              2'd1:    shadow_d[7:4]   = digitIn;
              2'd2:    shadow_d[11:8]  = digitIn;
              default: shadow_d[15:12] = digitIn;
            endcase
            tcnt_d = '0;
            if (slot_q == 2'd3) begin
              state_d = ST_COMMIT;
            end else begin
              slot_d = slot_q + 2'd1;
            end
          end else if (tmo_last) begin
            tout_d   = 1'b1;
            shadow_d = '0;
            state_d  = ST_OPEN;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end

        ST_COMMIT: begin
          store_d = shadow_q;
          done_d  = 1'b1;
          state_d = ST_OPEN;
        end

        ST_LOCK: begin
          // Only reached with lockDownIn low: the lockdown has been lifted.
          restart_d = 1'b1;
          state_d   = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d != state_q) begin
      tcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      slot_q    <= '0;
      tcnt_q    <= '0;
      store_q   <= DEFAULT_PASSWORD;
      shadow_q  <= '0;
      en_q      <= 1'b0;
      dig_q     <= '0;
      restart_q <= 1'b0;
      tout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      slot_q    <= slot_d;
      tcnt_q    <= tcnt_d;
      store_q   <= store_d;
      shadow_q  <= shadow_d;
      en_q      <= en_d;
      dig_q     <= dig_d;
      restart_q <= restart_d;
      tout_q    <= tout_d;
      done_q    <= done_d;
    end
  end

  // Validator read port sees only the committed store, never the shadow.
  always_comb begin
    dataRd = store_q[3:0];
    unique case (addrRd)
      2'd0:    dataRd = store_q[3:0];
      2'd1:    dataRd = store_q[7:4];
      2'd2:    dataRd = store_q[11:8];
      default: dataRd = store_q[15:12];
    endcase
  end

  assign enableOut  = en_q;
  assign digitOut   = dig_q;
  assign restartOut = restart_q;
  assign timeoutErr = tout_q;
  assign setDone    = done_q;
  assign isOpen     = (state_q == ST_OPEN) || (state_q == ST_SET) ||
                      (state_q == ST_COMMIT);
  assign dbgState   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_password_store_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_password_store_ctrl
// Purpose  : Self-checking bench for password_store_ctrl. A small validator
//            model answers the read port; expected behaviour comes from a
//            password array and per-scenario cycle arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_password_store_ctrl;

  localparam int          T   = 8;
  localparam logic [15:0] DEF = 16'h9210;

  logic       CLK;
  logic       RST;
  logic       digitValid;
  logic [3:0] digitIn;
  logic       setReq;
  logic       relockReq;
  logic [1:0] addrRd;
  logic [3:0] dataRd;
  logic       unlockIn;
  logic       lockDownIn;
  logic       enableOut;
  logic [3:0] digitOut;
  logic       restartOut;
  logic       timeoutErr;
  logic       setDone;
  logic       isOpen;
  logic [2:0] dbgState;

  password_store_ctrl #(.TIMEOUT_CYCLES(T), .DEFAULT_PASSWORD(DEF)) dut (
    .CLK(CLK), .RST(RST), .digitValid(digitValid), .digitIn(digitIn),
    .setReq(setReq), .relockReq(relockReq), .addrRd(addrRd), .dataRd(dataRd),
    .unlockIn(unlockIn), .lockDownIn(lockDownIn), .enableOut(enableOut),
    .digitOut(digitOut), .restartOut(restartOut), .timeoutErr(timeoutErr),
    .setDone(setDone), .isOpen(isOpen), .dbgState(dbgState)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- validator model ----------------
  logic [2:0] v_idx;
  logic       v_ok, unlock_r, lock_r;
  int         v_fails;
  logic       lock_arm, v_release, lock_force, addr_ovr;
  logic [1:0] tb_addr;

  assign addrRd     = addr_ovr ? tb_addr : v_idx[1:0];
  assign unlockIn   = unlock_r;
  assign lockDownIn = lock_r | lock_force;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v_idx <= 3'd0; v_ok <= 1'b1; unlock_r <= 1'b0; lock_r <= 1'b0; v_fails <= 0;
    end else begin
      if (v_release) begin lock_r <= 1'b0; v_fails <= 0; end
      if (restartOut) begin
        v_idx <= 3'd0; v_ok <= 1'b1; unlock_r <= 1'b0;
      end else if (enableOut && v_idx < 3'd4) begin
        v_idx <= v_idx + 3'd1;
        v_ok  <= v_ok && (digitOut == dataRd);
        if (v_idx == 3'd3) begin
          if (v_ok && digitOut == dataRd) unlock_r <= 1'b1;
          else if (lock_arm) begin
            v_fails <= v_fails + 1;
            if (v_fails == 2) lock_r <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- event monitor ----------------
  int         en_cyc[$];
  logic [3:0] en_dig[$];
  int         rs_cyc[$];
  int         to_cyc[$];
  int         sd_cyc[$];

  always @(negedge CLK) begin
    if (RST) begin
      if (enableOut)  begin en_cyc.push_back(cyc); en_dig.push_back(digitOut); end
      if (restartOut) rs_cyc.push_back(cyc);
      if (timeoutErr) to_cyc.push_back(cyc);
      if (setDone)    sd_cyc.push_back(cyc);
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_pw;
  bit model_open;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_q();
    en_cyc.delete(); en_dig.delete(); rs_cyc.delete(); to_cyc.delete(); sd_cyc.delete();
  endtask

  task automatic drive_digit(input logic [3:0] d);
    digitValid = 1'b1;
    digitIn    = d;
    tick();
    digitValid = 1'b0;
    digitIn    = 4'($urandom_range(0, 15));
  endtask

  // Idle cycles; with noise, some carry out-of-range digits that must be dropped.
  task automatic idle_cycles(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      if (noise && ($urandom_range(0, 1) == 1)) begin
        digitValid = 1'b1;
        digitIn    = 4'($urandom_range(15, 10));
      end
      tick();
      digitValid = 1'b0;
    end
  endtask

  task automatic read_all(input string tag);
    logic sv;
    sv = addr_ovr;
    addr_ovr = 1'b1;
    for (int a = 0; a < 4; a++) begin
      tb_addr = 2'(a);
      #1;
      chk(tag, dataRd, exp_pw[4*a +: 4]);
    end
    addr_ovr = sv;
  endtask

  function automatic logic [15:0] rand_pw();
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(9, 0));
    return p;
  endfunction

  function automatic logic [15:0] wrong_pw();
    logic [15:0] p;
    p = rand_pw();
    if (p == exp_pw) p[3:0] = (p[3:0] == 4'd9) ? 4'd0 : p[3:0] + 4'd1;
    return p;
  endfunction

  // Entry from IDLE: 4 digits with gaps; expects forwarding, then open/restart/lock.
  task automatic do_entry(input logic [15:0] d, input int gmin, input int gmax, input bit exp_lock);
    int dc[4];
    bit ok;
    int n;
    ok = (d == exp_pw);
    clr_q();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle_cycles(int'($urandom_range(gmax, gmin)), 1'b1);
      dc[i] = cyc;
      drive_digit(d[4*i +: 4]);
    end
    n = dc[3];
    idle_cycles(2, 1'b0);                       // cycle n+3
    chk("entry_open", isOpen, 32'(ok && !exp_lock));
    tick();                                     // cycle n+4
    chk("entry_en_count", en_cyc.size(), 4);
    for (int i = 0; i < 4 && i < en_cyc.size(); i++) begin
      chk("entry_en_cycle", en_cyc[i], dc[i] + 1);
      chk("entry_en_digit", en_dig[i], d[4*i +: 4]);
    end
    chk("entry_restarts", rs_cyc.size(), (ok || exp_lock) ? 0 : 1);
    if (!ok && !exp_lock && rs_cyc.size() == 1)
      chk("entry_restart_cycle", 32'(rs_cyc[0] == n + 2 || rs_cyc[0] == n + 3), 1);
    model_open = ok && !exp_lock;
  endtask

  // Change-password transaction from OPEN.
  task automatic do_set(input logic [15:0] np, input int gmin, input int gmax);
    int n;
    clr_q();
    addr_ovr = 1'b1;
    setReq = 1'b1;
    tick();
    setReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = int'($urandom_range(gmax, gmin)); k > 0; k--) begin
        if ($urandom_range(0, 1) == 1) begin digitValid = 1'b1; digitIn = 4'($urandom_range(15, 10)); end
        tb_addr = 2'($urandom_range(0, 3));
        #1;
        chk("set_store_hidden", dataRd, exp_pw[4*tb_addr +: 4]);
        tick();
        digitValid = 1'b0;
      end
      n = cyc;
      drive_digit(np[4*i +: 4]);
    end
    tb_addr = 2'($urandom_range(0, 3));         // COMMIT cycle: still old
    #1;
    chk("set_store_precommit", dataRd, exp_pw[4*tb_addr +: 4]);
    tick();                                     // cycle n+2
    chk("set_done_pulse", setDone, 1);
    chk("set_still_open", isOpen, 1);
    exp_pw = np;
    read_all("set_store_new");
    tick();
    chk("set_done_count", sd_cyc.size(), 1);
    if (sd_cyc.size() == 1) chk("set_done_cycle", sd_cyc[0], n + 2);
    chk("set_no_enable", en_cyc.size(), 0);
    chk("set_no_timeout", to_cyc.size(), 0);
    addr_ovr = 1'b0;
  endtask

  task automatic do_relock();
    relockReq = 1'b1;
    tick();
    relockReq = 1'b0;
    chk("relock_restart", restartOut, 1);
    chk("relock_closed", isOpen, 0);
    tick();
    chk("relock_single", restartOut, 0);
    model_open = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_enable"},  enableOut, 0);
    chk({tag, "_digit"},   digitOut, 0);
    chk({tag, "_restart"}, restartOut, 0);
    chk({tag, "_timeout"}, timeoutErr, 0);
    chk({tag, "_setdone"}, setDone, 0);
    chk({tag, "_isopen"},  isOpen, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST = 1'b0; digitValid = 1'b0; digitIn = 4'd0; setReq = 1'b0; relockReq = 1'b0;
    lock_arm = 1'b0; v_release = 1'b0; lock_force = 1'b0; addr_ovr = 1'b0; tb_addr = 2'd0;
    exp_pw = DEF; model_open = 1'b0;

    // ---- reset: outputs quiet, default store, digit during reset ignored
    tick();
    digitValid = 1'b1; digitIn = 4'd3;
    tick();
    chk_outputs_zero("reset");
    read_all("reset_store");
    digitValid = 1'b0;
    RST = 1'b1;
    tick(); tick();
    chk("post_reset_enable", enableOut, 0);

    // ---- default password unlocks, relock, wrong password rejected
    do_entry(DEF, 1, 1, 1'b0);
    do_relock();
    do_entry(16'h9310, 1, 1, 1'b0);

    // ---- entry timeout with a dropped digit 12 mid-entry; back-to-back digits
    clr_q();
    drive_digit(4'd4);
    n = cyc;
    drive_digit(4'd7);                          // cycle n+1
    idle_cycles(1, 1'b0);                       // cycle n+2
    digitValid = 1'b1; digitIn = 4'd12;
    tick();                                     // cycle n+3
    digitValid = 1'b0;
    idle_cycles(T - 3, 1'b0);                   // cycle n+T
    chk("tmo_not_early", timeoutErr, 0);
    tick();                                     // cycle n+T+1
    chk("tmo_pulse", timeoutErr, 1);
    chk("tmo_restart", restartOut, 1);
    chk("tmo_closed", isOpen, 0);
    tick();
    chk("tmo_count", to_cyc.size(), 1);
    chk("tmo_en_count", en_cyc.size(), 2);
    if (en_cyc.size() == 2) chk("tmo_back_to_back", en_cyc[1], en_cyc[0] + 1);

    // ---- digit exactly on the terminal timeout cycle is accepted
    do_entry(DEF, T - 1, T - 1, 1'b0);

    // ---- change password, relock, unlock with the new one
    do_set(16'h3755, 1, 2);                     // slots 0..3 = 5,5,7,3
    do_relock();
    do_entry(16'h3755, 0, 3, 1'b0);

    // ---- SET timeout: shadow discarded, stays open, no restart
    clr_q();
    setReq = 1'b1; tick(); setReq = 1'b0;
    drive_digit(4'd1);
    n = cyc;
    drive_digit(4'd2);                          // cycle n+1
    idle_cycles(T - 1, 1'b0);                   // cycle n+T
    chk("settmo_not_early", timeoutErr, 0);
    tick();
    chk("settmo_pulse", timeoutErr, 1);
    chk("settmo_open", isOpen, 1);
    chk("settmo_no_restart", restartOut, 0);
    read_all("settmo_store");
    tick();
    chk("settmo_count", to_cyc.size(), 1);

    // ---- lockdown arriving during COMMIT aborts the commit
    clr_q();
    setReq = 1'b1; tick(); setReq = 1'b0;
    drive_digit(4'd8); drive_digit(4'd8); drive_digit(4'd8); drive_digit(4'd8);
    lock_force = 1'b1;                          // COMMIT cycle
    tick();
    chk("abort_no_setdone", setDone, 0);
    chk("abort_closed", isOpen, 0);
    read_all("abort_store");
    lock_force = 1'b0;
    tick();
    chk("abort_release_restart", restartOut, 1);
    tick();
    chk("abort_setdone_count", sd_cyc.size(), 0);
    chk("abort_restart_count", rs_cyc.size(), 1);
    model_open = 1'b0;

    // ---- three wrong entries lock the validator; digits ignored in LOCK
    lock_arm = 1'b1;
    do_entry(wrong_pw(), 0, 2, 1'b0);
    do_entry(wrong_pw(), 0, 2, 1'b0);
    do_entry(wrong_pw(), 0, 2, 1'b1);
    clr_q();
    drive_digit(4'd2); idle_cycles(1, 1'b0); drive_digit(4'd6); idle_cycles(2, 1'b0);
    chk("lock_no_enable", en_cyc.size(), 0);
    chk("lock_no_restart", rs_cyc.size(), 0);
    chk("lock_closed", isOpen, 0);
    v_release = 1'b1;
    tick();
    v_release = 1'b0;
    chk("unlockdown_wait", restartOut, 0);
    tick();
    chk("unlockdown_restart", restartOut, 1);
    tick();
    chk("unlockdown_single", restartOut, 0);
    lock_arm = 1'b0;
    do_entry(exp_pw, 0, 2, 1'b0);

    // ---- randomized sessions
    for (int it = 0; it < 30; it++) begin
      if (!model_open) begin
        if ($urandom_range(0, 1) == 1) do_entry(exp_pw, 0, T - 1, 1'b0);
        else                           do_entry(wrong_pw(), 0, T - 1, 1'b0);
      end else if ($urandom_range(0, 2) != 0) begin
        do_set(rand_pw(), 0, T - 1);
      end else begin
        do_relock();
      end
    end

    // ---- asynchronous reset in the middle of SET
    if (!model_open) do_entry(exp_pw, 0, 2, 1'b0);
    setReq = 1'b1; tick(); setReq = 1'b0;
    drive_digit(4'd6); drive_digit(4'd6);
    RST = 1'b0;
    digitValid = 1'b1; digitIn = 4'd4;
    #1;
    chk_outputs_zero("midset_reset");
    exp_pw = DEF;
    read_all("midset_reset_store");
    tick();
    chk("midset_reset_enable", enableOut, 0);
    digitValid = 1'b0;
    RST = 1'b1;
    tick(); tick();
    chk("midset_post_enable", enableOut, 0);
    chk("midset_post_closed", isOpen, 0);
    do_entry(DEF, 0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
